// File: rtl/uart_line_rx_if.sv
// Line-receiver bus: uart receive strobes in, held-line read/ack port out.
// The slave modport is the line receiver itself; the master is its environment.
interface uart_line_rx_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              received;
  logic [7:0]        rx_byte;
  logic              recv_error;
  logic              line_valid;
  logic [ADDR_W:0]   line_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              line_ack;
  logic              overflow;
  logic              dropped;

  modport slave (
    input  received, rx_byte, recv_error, rd_addr, line_ack,
    output line_valid, line_len, rd_data, overflow, dropped
  );

  modport master (
    output received, rx_byte, recv_error, rd_addr, line_ack,
    input  line_valid, line_len, rd_data, overflow, dropped
  );
endinterface

// File: rtl/uart_line_rx.sv
// Assembles uart receive bytes into a line buffer, holds a completed line for a consumer.
// Optional UART_LINE_RX_CASEFOLD_EN stores 'a'..'z' as uppercase.
module uart_line_rx #(
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_line_rx_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic [7:0]      rd_q;
  logic            is_term;
  logic            full;
  logic [7:0]      mem [DEPTH];

  assign is_term = (bus.rx_byte == 8'h0A) || (bus.rx_byte == 8'h0D);
  // count never exceeds DEPTH, so its MSB alone flags a full buffer
  assign full    = count_q[ADDR_W];

`ifdef UART_LINE_RX_CASEFOLD_EN
  assign wr_data = (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h7A) ?
                   (bus.rx_byte - 8'h20) : bus.rx_byte;
`else
  assign wr_data = bus.rx_byte;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.received) begin
          if (is_term) begin
            if (count_q != '0) begin
              state_d = HOLD;
              len_d   = count_q;
              ovf_d   = 1'b0;
            end
          end else if (!full) begin
            wr_en   = 1'b1;
            count_d = count_q + (ADDR_W + 1)'(1);
          end else begin
            ovf_d   = 1'b1;
            state_d = DISCARD;
          end
        end else if (bus.recv_error) begin
          count_d = '0;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.received && is_term) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      HOLD: begin
        drop_d = bus.received;
        if (bus.line_ack) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      rd_q    <= mem[bus.rd_addr];
    end
  end

  // Buffer RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= wr_data;
  end

  assign bus.line_valid = (state_q == HOLD);
  assign bus.line_len   = len_q;
  assign bus.rd_data    = rd_q;
  assign bus.overflow   = ovf_q;
  assign bus.dropped    = drop_q;
endmodule

// File: tb/tb_uart_line_rx.sv
// Directed scoreboard bench for uart_line_rx (DEPTH=16); honours UART_LINE_RX_CASEFOLD_EN.
module tb_uart_line_rx;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   drop_cnt = 0;

  int         exp_len_q [$];
  logic [7:0] exp_byte_q [$];

  uart_line_rx_if #(.ADDR_W(4)) bus ();
  uart_line_rx #(.ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.dropped === 1'b1) drop_cnt++;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef UART_LINE_RX_CASEFOLD_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge
  task automatic send(input logic [7:0] b);
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.received = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_line(input string s);
    exp_len_q.push_back(s.len());
    for (int i = 0; i < s.len(); i++) exp_byte_q.push_back(fold(s[i]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_line();
    for (int t = 0; t < 40 && bus.line_valid !== 1'b1; t++) @(negedge clk);
    check("line_valid_rise", bus.line_valid, 1);
  endtask

  task automatic check_line();
    int len;
    logic [7:0] eb;
    if (exp_len_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=line expected=none");
      return;
    end
    len = exp_len_q.pop_front();
    check("line_len", bus.line_len, len);
    for (int i = 0; i < len; i++) begin
      bus.rd_addr = i[3:0];
      @(negedge clk);
      eb = exp_byte_q.pop_front();
      check($sformatf("rd_data[%0d]", i), bus.rd_data, eb);
    end
  endtask

  task automatic ack();
    bus.line_ack = 1'b1;
    @(negedge clk);
    bus.line_ack = 1'b0;
    check("valid_after_ack", bus.line_valid, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_line_valid", bus.line_valid, 0);
    check("rst_line_len", bus.line_len, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_dropped", bus.dropped, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.received = 1'b0;
    bus.rx_byte = '0;
    bus.recv_error = 1'b0;
    bus.rd_addr = '0;
    bus.line_ack = 1'b0;
    idle(3);
    check_reset_vals();
    rst = 1'b0;
    idle(2);

    // Full framing at back-to-back strobes; trailing CR lands in HOLD and is dropped
    drop_cnt = 0;
    push_line("Hello World!");
    send_str("Hello World!\n\r");
    wait_line();
    check_line();
    check("hello_cr_dropped", drop_cnt, 1);
    ack();
    idle(5);
    check("no_second_line", bus.line_valid, 0);

    // Exactly DEPTH bytes is a legal line
    push_line("abcdefghijklmnop");
    send_str("abcdefghijklmnop\n");
    wait_line();
    check("full_line_no_ovf", bus.overflow, 0);
    check_line();
    ack();

    // DEPTH+1 bytes overflow, then the next line clears overflow
    for (int i = 0; i < 17; i++) send(8'h41);
    send(8'h0A);
    idle(5);
    check("ovf_no_line", bus.line_valid, 0);
    check("ovf_set", bus.overflow, 1);
    push_line("AB");
    send_str("AB\n");
    wait_line();
    check("ovf_cleared", bus.overflow, 0);
    check_line();
    ack();

    // Bytes arriving while held are dropped and leave the buffer alone
    push_line("QRS");
    send_str("QRS\n");
    wait_line();
    idle(1);
    drop_cnt = 0;
    send_str("xyz");
    check_line();
    check("hold_drops", drop_cnt, 3);
    ack();
    push_line("X");
    send_str("X\n");
    wait_line();
    check_line();
    ack();

    // Framing error discards the partial line through the next terminator
    send_str("AB");
    bus.recv_error = 1'b1;
    @(negedge clk);
    bus.recv_error = 1'b0;
    send_str("CD\n");
    push_line("EF");
    send_str("EF\n");
    wait_line();
    check_line();
    ack();

    // Byte coincident with ack is dropped, not stored in the next line
    push_line("M");
    send_str("M\n");
    wait_line();
    check_line();
    drop_cnt = 0;
    bus.line_ack = 1'b1;
    bus.received = 1'b1;
    bus.rx_byte  = 8'h5A;
    @(negedge clk);
    bus.line_ack = 1'b0;
    bus.received = 1'b0;
    check("coinc_valid_fall", bus.line_valid, 0);
    @(negedge clk);
    check("coinc_dropped", drop_cnt, 1);
    push_line("N");
    send_str("N\n");
    wait_line();
    check_line();
    ack();

    // Reset mid-line with overflow set aborts everything
    for (int i = 0; i < 17; i++) send(8'h41);
    send(8'h0A);
    idle(1);
    check("ovf_before_rst", bus.overflow, 1);
    send_str("ABC");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    push_line("Q");
    send_str("Q\n");
    wait_line();
    check_line();
    ack();

    check("sb_drained", exp_len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Receive-side line assembler that sits directly behind the `uart` core's receive outputs (`received`, `rx_byte`, `recv_error`). It collects incoming bytes into an internal buffer until a line terminator arrives, then holds the completed line for a consumer. The consumer reads the line bytes through a registered random-access port and releases the buffer with an acknowledge. This is the receive counterpart of the periodic "Hello World!\n\r" transmit path and accepts that same framing.

## Interface
Parameters:
- `ADDR_W`, default 4: buffer address width; buffer depth is `DEPTH = 2**ADDR_W` bytes, which is the longest storable line.

Ports:
- `clk`  in  1  master clock, shared with `uart`.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `received`  in  1  one-cycle strobe from `uart`: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `recv_error`  in  1  one-cycle strobe from `uart`: framing error.
- `line_valid`  out  1  a completed line is held; buffer contents are stable.
- `line_len`  out  ADDR_W+1  number of bytes in the held line, 1..DEPTH; terminator not stored.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  8  buffer byte at `rd_addr`, registered.
- `line_ack`  in  1  consumer releases the held line; sampled only while `line_valid`=1.
- `overflow`  out  1  sticky: the most recent line exceeded DEPTH and was discarded.
- `dropped`  out  1  one-cycle pulse for each byte dropped while a line is held.

## Operation
- Terminator: `rx_byte` equal to 8'h0A or 8'h0D.
- FSM states: COLLECT (reset state), HOLD, DISCARD. Internal `count` has width ADDR_W+1 and is cleared to 0 on reset.
- COLLECT, `received` with a terminator:
  - If `count`=0, the byte is ignored. Empty lines and the second byte of a CR/LF or LF/CR pair produce nothing.
  - Otherwise go to HOLD and latch `line_len`=`count`.
- COLLECT, `received` with a non-terminator:
  - If `count`<DEPTH, write `buf[count]`=byte and increment `count`.
  - If `count`=DEPTH, set `overflow`=1 and go to DISCARD.
- COLLECT, `recv_error`: clear `count` to 0 and go to DISCARD. The partial line is lost; `overflow` is unchanged.
- DISCARD: ignore all bytes until a terminator arrives, then go to COLLECT with `count`=0.
- HOLD:
  - `line_valid`=1.
  - Each `received` is dropped and pulses `dropped`. `recv_error` is ignored.
  - `line_ack`=1 returns the FSM to COLLECT and clears `count`.
- `overflow` clears when the next line enters HOLD, or on `rst`.
- Buffer writes occur only in COLLECT. The buffer is never modified while `line_valid`=1.
- Buffer RAM contents are not reset. Only the registers listed under Timing are reset.

## Timing
- Reset values: `line_valid`=0, `line_len`=0, `rd_data`=8'h00, `overflow`=0, `dropped`=0, FSM=COLLECT.
- `line_valid` rises on the cycle after the terminator's `received` strobe. `line_len` is valid from that same cycle.
- `rd_data` has 1-cycle latency: it reflects `buf[rd_addr]` as sampled at the previous edge. Reads are legal in any state, but data is defined only while `line_valid`=1.
- `line_ack` falls into `line_valid`=0 on the next cycle. A `received` strobe in the same cycle as `line_ack` is dropped and pulses `dropped`; the ack takes effect afterwards.
- Earliest next-line byte acceptance is the cycle after `line_valid` falls.
- `dropped` pulses in the cycle after the dropped strobe.
- `rst` asserted mid-line or in HOLD aborts everything and returns all registers to reset values on the next edge.
- Back-to-back `received` strobes on consecutive cycles must be accepted. The `uart` core never produces them, but the bench does.

## Configuration
- `UART_LINE_RX_CASEFOLD_EN` defined: bytes 8'h61..8'h7A ('a'..'z') are stored as the byte minus 8'h20 (uppercase). All other bytes, and terminator detection, are unchanged.
- Undefined: bytes are stored verbatim.

## Test plan
- "Hello World!\n\r" at back-to-back strobes -> `line_valid`=1, `line_len`=12, reading addresses 0..11 returns "Hello World!". With CASEFOLD_EN, reading returns "HELLO WORLD!". The trailing 8'h0D produces no second line.
- With DEPTH=16, send 17 × 8'h41 then 8'h0A -> no `line_valid`, `overflow`=1. Then send "AB\n" -> `line_valid`=1, `line_len`=2, `overflow`=0.
- Hold a line, send 3 bytes, then `line_ack` -> 3 `dropped` pulses, buffer unchanged, `line_valid`=0 one cycle after ack. Next "X\n" gives `line_len`=1, rd 0 = 8'h58.
- Send "AB", then `recv_error`, then "CD\n", then "EF\n" -> the first line is discarded through "CD\n". The held line is "EF", `line_len`=2.
- `line_ack` coincident with `received`=8'h5A -> `dropped` pulses and the following line does not contain 8'h5A.
- Send "ABC", assert `rst` for 1 cycle, then send "Q\n" -> all outputs at reset values after reset, then `line_len`=1, rd 0 = 8'h51.
